// File: rtl/mem_responder_pkg.sv
// Shared definitions for the single-outstanding memory responder: FSM encoding,
// data/lane widths and the request legality check.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int DATA_W    = 32;
    localparam int NUM_LANES = DATA_W / BYTE_W;
    localparam int CNT_W     = 4;

    // A request errors when it is not word aligned or its word index is past the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with a synchronous byte-enabled write port and a
// combinational read port. Contents are never reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 wen,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] be,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with fixed response latency.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  fsm_state
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] rd_word;

    assign accept    = req_valid && req_ready;
    assign req_err   = addr_err(req_addr, DEPTH_WORDS);
    assign fsm_state = state;

    // Stores commit on the accept edge; loads read the pre-edge word through the
    // combinational port, so a load always sees a snapshot taken before accept.
    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .wen   (accept && req_wen && !req_err),
        .waddr (req_addr[ADDR_W+1:2]),
        .wdata (req_wdata),
        .be    (req_be),
        .raddr (req_addr[ADDR_W+1:2]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= LAT_RELOAD;
                        rsp_err   <= req_err;
                        rsp_rdata <= (req_err || req_wen) ? '0 : rd_word;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Entering RESP on the edge the counter reaches 0 makes rsp_valid
                    // visible in the LATENCY-th cycle counted from the accept edge.
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 uses LATENCY 2 / 1024 words,
// instance 1 uses LATENCY 1 / 16 words; a negedge monitor scores every response.
module tb_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [1:0]  fsm_state [2];

    logic [32:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int acc_edge    [2];
    bit have_acc    [2];
    bit spacing_chk [2];
    bit prev_valid  [2];

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .fsm_state(fsm_state[0])
    );

    mem_responder #(.DEPTH_WORDS(16), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .fsm_state(fsm_state[1])
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request and return #1 after its accept edge.
    task automatic issue(input int s, input bit push, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic e_err, input logic [31:0] e_rdata, input bit keep);
        bit acc;
        acc = 1'b0;
        if (push) exp_q.push_back({e_err, e_rdata});
        req_valid[s] = 1'b1;
        req_wen[s]   = wen;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        req_be[s]    = be;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = req_ready[s];
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'(acc), 32'd1);
        if (!keep) begin
            req_valid[s] = 1'b0;
            req_wen[s]   = 1'($urandom_range(0, 1));
            req_addr[s]  = $urandom;
            req_wdata[s] = $urandom;
            req_be[s]    = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain(input int s);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && req_ready[s];
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) prev_valid[k] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int lat;
                logic [32:0] e;
                lat = (k == 0) ? LAT_A : LAT_B;
                if (req_valid[k] && req_ready[k]) begin
                    if (spacing_chk[k] && have_acc[k])
                        check("accept_period", 32'(cyc + 1 - acc_edge[k]), 32'(lat + 1));
                    acc_edge[k] = cyc + 1;
                    have_acc[k] = 1'b1;
                end
                if (rsp_valid[k] && !prev_valid[k])
                    check("rsp_latency", 32'(cyc - acc_edge[k] + 1), 32'(lat));
                if (rsp_valid[k] && rsp_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got response %h with nothing expected", rsp_rdata[k]);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata[k], e[31:0]);
                        check("rsp_err", 32'(rsp_err[k]), 32'(e[32]));
                    end
                end
                prev_valid[k] = rsp_valid[k];
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   req_be[k] = '0;    rsp_ready[k] = 1'b1;
            have_acc[k] = 1'b0;  spacing_chk[k] = 1'b0; acc_edge[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check("reset_req_ready", 32'(req_ready[k]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("reset_rsp_err",   32'(rsp_err[k]),   32'd0);
            check("reset_rsp_rdata", rsp_rdata[k],      32'd0);
            check("reset_state",     32'(fsm_state[k]), 32'd0);
        end

        // Store then load, full word
        issue(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
        // Partial byte-enable merge and be=0 no-op
        issue(0, 1, 1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 0);
        issue(0, 1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0, 0);
        issue(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 0);
        issue(0, 1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 0);
        issue(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 0);
        // Word 0 and last word, then erroring accesses that must not touch memory
        issue(0, 1, 1, 32'h0,   32'h01020304, 4'hF, 0, 32'h0, 0);
        issue(0, 1, 1, 32'hFFC, 32'h0BADCAFE, 4'hF, 0, 32'h0, 0);
        issue(0, 1, 0, 32'h22,   32'h0, 4'h0, 1, 32'h0, 0);
        issue(0, 1, 0, 32'h1000, 32'h0, 4'h0, 1, 32'h0, 0);
        issue(0, 1, 1, 32'h22,   32'h55555555, 4'hF, 1, 32'h0, 0);
        issue(0, 1, 1, 32'h1000, 32'h66666666, 4'hF, 1, 32'h0, 0);
        issue(0, 1, 0, 32'h20,  32'h0, 4'h0, 0, 32'h11BB33DD, 0);
        issue(0, 1, 0, 32'h0,   32'h0, 4'h0, 0, 32'h01020304, 0);
        issue(0, 1, 0, 32'hFFC, 32'h0, 4'h0, 0, 32'h0BADCAFE, 0);
        drain(0);

        // Response back-pressure with a second request waiting
        rsp_ready[0] = 1'b0;
        issue(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
        exp_q.push_back({1'b0, 32'h11BB33DD});
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h20;
        for (int i = 0; i < 20 && !rsp_valid[0]; i++) begin
            @(posedge clk);
            #1;
        end
        check("stall_rsp_valid_seen", 32'(rsp_valid[0]), 32'd1);
        repeat (5) begin
            check("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("stall_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("stall_req_ready", 32'(req_ready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_req_ready", 32'(req_ready[0]), 32'd1);
        check("post_hs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("second_accepted", 32'(req_ready[0]), 32'd0);
        check("second_state_wait", 32'(fsm_state[0]), 32'd1);
        req_valid[0] = 1'b0;
        drain(0);

        // Reset while a committed store is waiting for its response
        issue(0, 0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0);
        check("pre_reset_state_wait", 32'(fsm_state[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mid_reset_state", 32'(fsm_state[0]), 32'd0);
        check("mid_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("mid_reset_req_ready", 32'(req_ready[0]), 32'd1);
        issue(0, 1, 0, 32'h40, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
        drain(0);

        // LATENCY 1, continuous requests with rsp_ready held high
        spacing_chk[1] = 1'b1;
        issue(1, 1, 1, 32'h0,  32'hAAAA0001, 4'hF, 0, 32'h0, 1);
        issue(1, 1, 1, 32'h3C, 32'h12345678, 4'hF, 0, 32'h0, 1);
        issue(1, 1, 0, 32'h0,  32'h0, 4'h0, 0, 32'hAAAA0001, 1);
        issue(1, 1, 0, 32'h3C, 32'h0, 4'h0, 0, 32'h12345678, 1);
        issue(1, 1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h0, 1);
        issue(1, 1, 0, 32'h3C, 32'h0, 4'h0, 0, 32'h12345678, 0);
        drain(1);
        spacing_chk[1] = 1'b0;

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, 16..65536.
REQ-002 Parameter LATENCY, default 2, cycles from request accept edge to rsp_valid assertion; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_wen  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i enables wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response presented.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 exactly when the state is IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-017 Only one transaction SHALL be outstanding at a time.
REQ-018 On accept, address, wen, wdata, and be SHALL be captured; an error is flagged if req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS.
REQ-019 A legal store SHALL update only the enabled bytes of word req_addr[31:2] on the accept edge; req_be = 0 SHALL be a legal no-op store.
REQ-020 A legal load SHALL capture the word at req_addr[31:2] on the accept edge.
REQ-021 Load data SHALL be a pre-accept snapshot and SHALL NOT change afterwards.
REQ-022 An erroring request SHALL NOT modify memory; its response SHALL carry rsp_err = 1 and rsp_rdata = 0.
REQ-023 After accept, a down-counter SHALL be loaded with LATENCY-1.
REQ-024 If LATENCY = 1, the FSM SHALL go directly IDLE -> RESP; otherwise IDLE -> WAIT, and WAIT -> RESP when the counter reaches 0.
REQ-025 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-026 In RESP, rsp_valid = 1, and rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready = 1.
REQ-027 On that edge the FSM SHALL go RESP -> IDLE; rsp_valid drops and req_ready rises in the following cycle.
REQ-028 There SHALL be no same-cycle response/request turnaround.
REQ-029 rsp_ready SHALL be ignored outside RESP; req_valid and request fields SHALL be ignored outside IDLE.
REQ-030 Back-to-back transactions SHALL have a minimum period of LATENCY+1 cycles when rsp_ready is held at 1.

Reset
REQ-031 While reset = 1 at an edge: state goes to IDLE, counter to 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-transaction SHALL discard the pending response without retry; a store already committed at its accept edge SHALL remain.
REQ-033 Memory array contents SHALL NOT be reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2) and the byte-lane width constant.
REQ-035 Storage SHALL be one sub-module, mem_array: synchronous byte-enabled write port and combinational word read port, parameterised by DEPTH_WORDS.
REQ-036 The FSM, latency counter, and response registers SHALL stay in mem_responder.

Verification
REQ-037 LATENCY = 2: store addr 0x10, data 0xDEADBEEF, be 0xF; then load 0x10 with rsp_ready = 1 -> rsp_valid exactly 2 cycles after each accept; rdata = 0xDEADBEEF; err = 0.
REQ-038 Store 0x11223344 to 0x20, then store 0xAABBCCDD with be 0x5, then load 0x20 -> rdata = 0x11BB33DD.
REQ-039 Load 0x22 (misaligned) and load 4*DEPTH_WORDS (out of range) -> rsp_err = 1, rdata = 0; memory unchanged on readback.
REQ-040 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rdata stable and req_ready = 0 throughout; the second req_valid is not accepted until the cycle after the rsp handshake.
REQ-041 Assert reset during WAIT after a store -> next cycle IDLE with rsp_valid = 0; a subsequent load returns the stored data.
REQ-042 LATENCY = 1 with rsp_ready held at 1 and continuous requests -> one accept every 2 cycles; rsp_valid 1 cycle after each accept.
